// File: rtl/udma_rx_byte_packer.sv
//==============================================================================
// Module   : udma_rx_byte_packer
// Brief    : Packs a peripheral byte stream into 1/2/4-byte little-endian words
//            for the UDMA linear-channel rx path, with flush and idle timeout.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module udma_rx_byte_packer #(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 cfg_en_i,
  input  logic                 cfg_clr_i,
  input  logic [1:0]           cfg_datasize_i,
  input  logic [TIMEOUT_W-1:0] cfg_timeout_i,
  input  logic                 flush_i,
  input  logic [7:0]           byte_data_i,
  input  logic                 byte_valid_i,
  output logic                 byte_ready_o,
  output logic [31:0]          data_o,
  output logic [1:0]           datasize_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 flush_done_o
);

  localparam logic [1:0] c_size_byte = 2'b00;
  localparam logic [1:0] c_size_half = 2'b01;
  localparam logic [1:0] c_size_word = 2'b10;

  logic [23:0]          r_pack;
  logic [1:0]           r_count;
  logic [1:0]           r_size;
  logic                 r_flush_pend;
  logic [TIMEOUT_W-1:0] r_tmo;
  logic                 r_out_flushed;

  logic                 w_out_free;
  logic                 w_accept;
  logic                 w_drain;
  logic [1:0]           w_cfg_size;
  logic [1:0]           w_cur_size;
  logic [1:0]           w_last_idx;
  logic                 w_complete;
  logic                 w_tmo_en;
  logic                 w_tmo_hit;
  logic                 w_flush_req;
  logic [2:0]           w_fill;
  logic                 w_emit_part;
  logic                 w_emit;
  logic                 w_pend_next;
  logic [31:0]          w_word;
  logic [1:0]           w_part_size;

  assign w_out_free   = ~valid_o | ready_i;
  assign byte_ready_o = cfg_en_i & ~cfg_clr_i & w_out_free;
  assign w_accept     = byte_valid_i & byte_ready_o;
  assign w_drain      = valid_o & ready_i;

  // The target size is only sampled on byte 0; later bytes reuse the latched value.
  assign w_cfg_size = (cfg_datasize_i == 2'b11) ? c_size_word : cfg_datasize_i;
  assign w_cur_size = (r_count == 2'd0) ? w_cfg_size : r_size;

  always_comb begin
    w_last_idx = 2'd3;
    case (w_cur_size)
      c_size_byte: w_last_idx = 2'd0;
      c_size_half: w_last_idx = 2'd1;
      default:     w_last_idx = 2'd3;
    endcase
  end

  assign w_complete  = w_accept & (r_count == w_last_idx);
  assign w_tmo_en    = (cfg_timeout_i != '0) & (r_count != 2'd0);
  assign w_tmo_hit   = w_tmo_en & (r_tmo >= cfg_timeout_i);
  assign w_flush_req = flush_i | w_tmo_hit;
  assign w_fill      = {1'b0, r_count} + {2'b00, w_accept};

  // A pending flush always has bytes behind it, since it is cleared whenever
  // the byte count returns to zero.
  assign w_emit_part = r_flush_pend & w_out_free & ~w_complete;
  assign w_emit      = w_complete | w_emit_part;
  assign w_pend_next = ~w_emit & (r_flush_pend | (w_flush_req & (w_fill != 3'd0)));

  always_comb begin
    w_word = {8'h00, r_pack};
    if (w_accept) begin
      case (r_count)
        2'd0:    w_word[7:0]   = byte_data_i;
        2'd1:    w_word[15:8]  = byte_data_i;
        2'd2:    w_word[23:16] = byte_data_i;
        default: w_word[31:24] = byte_data_i;
      endcase
    end
  end

  always_comb begin
    w_part_size = c_size_word;
    case (w_fill)
      3'd1:    w_part_size = c_size_byte;
      3'd2:    w_part_size = c_size_half;
      default: w_part_size = c_size_word;
    endcase
  end

  // Packing state: byte count, partial word, latched size, flush and timeout.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_pack       <= '0;
      r_count      <= '0;
      r_size       <= '0;
      r_flush_pend <= 1'b0;
      r_tmo        <= '0;
    end else if (cfg_clr_i) begin
      r_pack       <= '0;
      r_count      <= '0;
      r_flush_pend <= 1'b0;
      r_tmo        <= '0;
    end else begin
      r_flush_pend <= w_pend_next;
      if (w_emit) begin
        r_pack  <= '0;
        r_count <= '0;
      end else if (w_accept) begin
        r_pack  <= w_word[23:0];
        r_count <= r_count + 2'd1;
      end
      if (w_accept && (r_count == 2'd0)) begin
        r_size <= w_cfg_size;
      end
      if (w_accept || w_emit) begin
        r_tmo <= '0;
      end else if (w_tmo_en && (r_tmo < cfg_timeout_i)) begin
        r_tmo <= r_tmo + TIMEOUT_W'(1);
      end
    end
  end

  // Output word register toward the linear channel.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_o        <= '0;
      datasize_o    <= '0;
      valid_o       <= 1'b0;
      r_out_flushed <= 1'b0;
      flush_done_o  <= 1'b0;
    end else if (cfg_clr_i) begin
      valid_o       <= 1'b0;
      r_out_flushed <= 1'b0;
      flush_done_o  <= 1'b0;
    end else begin
      flush_done_o <= w_drain & r_out_flushed;
      if (w_emit) begin
        data_o        <= w_word;
        datasize_o    <= w_complete ? w_cur_size : w_part_size;
        valid_o       <= 1'b1;
        r_out_flushed <= w_emit_part | r_flush_pend | w_flush_req;
      end else if (w_drain) begin
        valid_o       <= 1'b0;
        r_out_flushed <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_udma_rx_byte_packer.sv
//==============================================================================
// Module   : tb_udma_rx_byte_packer
// Brief    : Directed self-checking bench for udma_rx_byte_packer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_udma_rx_byte_packer;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        cfg_en_i = 1'b1;
  logic        cfg_clr_i = 1'b0;
  logic [1:0]  cfg_datasize_i = 2'b10;
  logic [15:0] cfg_timeout_i = 16'd0;
  logic        flush_i = 1'b0;
  logic [7:0]  byte_data_i = 8'h00;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic [31:0] data_o;
  logic [1:0]  datasize_o;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic        flush_done_o;

  int n_cmp = 0;
  int n_err = 0;

  udma_rx_byte_packer #(.TIMEOUT_W(16)) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .cfg_en_i       (cfg_en_i),
    .cfg_clr_i      (cfg_clr_i),
    .cfg_datasize_i (cfg_datasize_i),
    .cfg_timeout_i  (cfg_timeout_i),
    .flush_i        (flush_i),
    .byte_data_i    (byte_data_i),
    .byte_valid_i   (byte_valid_i),
    .byte_ready_o   (byte_ready_o),
    .data_o         (data_o),
    .datasize_o     (datasize_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .flush_done_o   (flush_done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Offer one byte and hold it until the edge that accepts it.
  task automatic push(input logic [7:0] b);
    int n;
    n = 0;
    byte_data_i  = b;
    byte_valid_i = 1'b1;
    #1;
    while (!byte_ready_o && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("push_timeout", 32'd0, 32'd1);
    tick();
    byte_valid_i = 1'b0;
  endtask

  task automatic pulse_flush();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int lat);
    lat = 0;
    while (!valid_o && lat < max) begin
      tick();
      lat++;
    end
    if (!valid_o) check("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    logic seen;

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_data", data_o, 32'h0);
    check("rst_size", {30'd0, datasize_o}, 32'd0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_fdone", {31'd0, flush_done_o}, 32'd0);
    rstn_i = 1'b1;
    tick();
    check("rst_bready", {31'd0, byte_ready_o}, 32'd1);

    // Full 4-byte word
    cfg_datasize_i = 2'b10;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    check("w4_valid", {31'd0, valid_o}, 32'd1);
    check("w4_data", data_o, 32'h44332211);
    check("w4_size", {30'd0, datasize_o}, 32'd2);
    tick();
    check("w4_drained", {31'd0, valid_o}, 32'd0);

    // Byte mode, back-to-back
    cfg_datasize_i = 2'b00;
    for (int i = 0; i < 4; i++) begin
      push(8'hC1 + 8'(i));
      check("b1_valid", {31'd0, valid_o}, 32'd1);
      check("b1_data", data_o, {24'd0, 8'hC1 + 8'(i)});
      check("b1_size", {30'd0, datasize_o}, 32'd0);
      check("b1_bready", {31'd0, byte_ready_o}, 32'd1);
    end
    tick();

    // Flush of a 3-byte partial word
    cfg_datasize_i = 2'b10;
    push(8'hAA); push(8'hBB); push(8'hCC);
    check("fl_novalid", {31'd0, valid_o}, 32'd0);
    pulse_flush();
    wait_valid(10, lat);
    check("fl_data", data_o, 32'h00CCBBAA);
    check("fl_size", {30'd0, datasize_o}, 32'd2);
    tick();
    check("fl_done", {31'd0, flush_done_o}, 32'd1);
    check("fl_drained", {31'd0, valid_o}, 32'd0);
    tick();
    check("fl_done_pulse", {31'd0, flush_done_o}, 32'd0);

    // Backpressure in half-word mode
    cfg_datasize_i = 2'b01;
    ready_i = 1'b0;
    push(8'h01); push(8'h02);
    byte_data_i  = 8'h03;
    byte_valid_i = 1'b1;
    #1;
    check("bp_bready0", {31'd0, byte_ready_o}, 32'd0);
    tick();
    check("bp_hold_valid", {31'd0, valid_o}, 32'd1);
    check("bp_hold_data", data_o, 32'h00000201);
    check("bp_hold_size", {30'd0, datasize_o}, 32'd1);
    ready_i = 1'b1;
    #1;
    check("bp_bready1", {31'd0, byte_ready_o}, 32'd1);
    tick();
    byte_valid_i = 1'b0;
    check("bp_drain", {31'd0, valid_o}, 32'd0);
    push(8'h04);
    check("bp_next_data", data_o, 32'h00000403);
    tick();

    // Size latched on byte 0; size 11 behaves as word
    cfg_datasize_i = 2'b01;
    push(8'h10);
    cfg_datasize_i = 2'b10;
    push(8'h20);
    check("lat_valid", {31'd0, valid_o}, 32'd1);
    check("lat_data", data_o, 32'h00002010);
    check("lat_size", {30'd0, datasize_o}, 32'd1);
    cfg_datasize_i = 2'b11;
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    check("s11_data", data_o, 32'hA4A3A2A1);
    check("s11_size", {30'd0, datasize_o}, 32'd2);
    tick();

    // Idle timeout
    cfg_datasize_i = 2'b10;
    cfg_timeout_i  = 16'd5;
    push(8'h5A);
    wait_valid(20, lat);
    check("to_latency", {31'd0, (lat >= 5 && lat <= 8)}, 32'd1);
    check("to_data", data_o, 32'h0000005A);
    check("to_size", {30'd0, datasize_o}, 32'd0);
    tick();
    check("to_fdone", {31'd0, flush_done_o}, 32'd1);

    cfg_timeout_i = 16'd0;
    push(8'h66);
    seen = 1'b0;
    repeat (30) begin
      tick();
      if (valid_o) seen = 1'b1;
    end
    check("to_disabled", {31'd0, seen}, 32'd0);
    pulse_flush();
    wait_valid(10, lat);
    check("to_dis_flush_data", data_o, 32'h00000066);
    tick();

    // Clear drops packed bytes and the output word, no flush_done
    cfg_datasize_i = 2'b10;
    push(8'h01); push(8'h02);
    cfg_clr_i = 1'b1;
    #1;
    check("clr_bready", {31'd0, byte_ready_o}, 32'd0);
    tick();
    cfg_clr_i = 1'b0;
    ready_i = 1'b0;
    push(8'h05); push(8'h06); push(8'h07); push(8'h08);
    check("clr_restart_data", data_o, 32'h08070605);
    check("clr_restart_valid", {31'd0, valid_o}, 32'd1);
    cfg_clr_i = 1'b1;
    tick();
    cfg_clr_i = 1'b0;
    check("clr_valid0", {31'd0, valid_o}, 32'd0);
    push(8'h09);
    pulse_flush();
    wait_valid(10, lat);
    check("clr_fl_data", data_o, 32'h00000009);
    cfg_clr_i = 1'b1;
    ready_i = 1'b1;
    tick();
    cfg_clr_i = 1'b0;
    check("clr_fl_valid0", {31'd0, valid_o}, 32'd0);
    check("clr_no_fdone", {31'd0, flush_done_o}, 32'd0);
    tick();
    check("clr_no_fdone2", {31'd0, flush_done_o}, 32'd0);

    // Async reset mid-word
    push(8'hE1); push(8'hE2);
    #2;
    rstn_i = 1'b0;
    #1;
    check("arst_valid", {31'd0, valid_o}, 32'd0);
    check("arst_data", data_o, 32'h0);
    rstn_i = 1'b1;
    tick();
    push(8'h31); push(8'h32); push(8'h33); push(8'h34);
    check("arst_restart", data_o, 32'h34333231);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
